// File: rtl/product_register.sv
// -----------------------------------------------------------------------------
// product_register
//
// Sequential unsigned WIDTH x WIDTH shift-add multiplier. It holds the
// 2*WIDTH-bit Product register, a WIDTH+1-bit adder and an iteration counter.
// An operation is started by a rising edge of run. It then takes WIDTH
// iterations, at one bit of the multiplier per clock. The exact 2*WIDTH-bit
// product is then held on Hi/Lo until the next start or reset.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous active-low reset
//   run           in   1      start request (rising edge only)
//   Multiplicand  in   WIDTH  operand A, captured at start
//   Multiplier    in   WIDTH  operand B, captured at start into Lo
//   Hi            out  WIDTH  Product upper half
//   Lo            out  WIDTH  Product lower half
//   counting      out  1      iterations in progress
//   ready         out  1      Hi/Lo hold a completed result
// -----------------------------------------------------------------------------
module product_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [WIDTH-1:0] Multiplicand,
    input  logic [WIDTH-1:0] Multiplier,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             counting,
    output logic             ready
);

    // Counter is one bit wider than log2(WIDTH) so it can never wrap early.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_prod;
    logic [WIDTH-1:0]       r_mcand;
    logic [CW-1:0]          r_cnt;
    logic                   r_run_d;

    logic [WIDTH:0]         w_sum;
    logic                   w_start;

    // Adder on the upper half of Product and start-edge detection.
    always_comb begin
        w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_start = run & ~r_run_d;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_prod  <= {(2*WIDTH){1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_run_d <= 1'b0;
        end else begin
            r_run_d <= run;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_prod  <= {{WIDTH{1'b0}}, Multiplier};
                        r_mcand <= Multiplicand;
                        r_cnt   <= {CW{1'b0}};
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_BUSY: begin
                    // The adder carry becomes the new MSB, so no product bit is lost.
                    if (r_prod[0]) begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end else begin
                        r_prod <= {1'b0, r_prod[2*WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are taken straight from registers; nothing depends combinationally on run.
    assign Hi       = r_prod[2*WIDTH-1:WIDTH];
    assign Lo       = r_prod[WIDTH-1:0];
    assign counting = (r_state == S_BUSY);
    assign ready    = (r_state == S_DONE);

endmodule

// File: tb/tb_product_register.sv
module tb_product_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] mcand_in = 32'd0;
    logic [31:0] mplier_in = 32'd0;
    logic [31:0] hi_o, lo_o;
    logic        counting_o, ready_o;

    int n_cmp = 0;
    int n_err = 0;

    product_register #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .Multiplicand (mcand_in),
        .Multiplier   (mplier_in),
        .Hi           (hi_o),
        .Lo           (lo_o),
        .counting     (counting_o),
        .ready        (ready_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 multiplying, 2 result held; k = iterations completed
    int          m_phase = 0;
    int          m_k = 0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic        m_run_d = 1'b0;

    // After k iterations the register holds A*(B mod 2^k) aligned at the top,
    // with the not-yet-consumed multiplier bits (B >> k) at the bottom.
    function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] mask;
        logic [63:0] part;
        mask = (64'd1 << k) - 64'd1;
        part = {32'd0, a} * ({32'd0, b} & mask);
        return (part << (32 - k)) | ({32'd0, b} >> k);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_k     <= 0;
            m_a     <= 32'd0;
            m_b     <= 32'd0;
            m_run_d <= 1'b0;
        end else begin
            m_run_d <= run;
            if (m_phase != 1 && run && !m_run_d) begin
                m_phase <= 1;
                m_k     <= 0;
                m_a     <= mcand_in;
                m_b     <= mplier_in;
            end else if (m_phase == 1) begin
                m_k <= m_k + 1;
                if (m_k + 1 == 32) m_phase <= 2;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        e = (m_phase == 0) ? 64'd0 : exp_prod(m_a, m_b, m_k);
        n_cmp = n_cmp + 3;
        if (counting_o !== (m_phase == 1)) begin
            n_err = n_err + 1;
            $display("FAIL model_counting t=%0t got=%0b exp=%0b", $time, counting_o, (m_phase == 1));
        end
        if (ready_o !== (m_phase == 2)) begin
            n_err = n_err + 1;
            $display("FAIL model_ready t=%0t got=%0b exp=%0b", $time, ready_o, (m_phase == 2));
        end
        if ({hi_o, lo_o} !== e) begin
            n_err = n_err + 1;
            $display("FAIL model_product t=%0t got=%h_%h exp=%h_%h", $time, hi_o, lo_o, e[63:32], e[31:0]);
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse run for one edge and count how many sampled cycles counting stays high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int busy);
        mcand_in  = a;
        mplier_in = b;
        run = 1'b1;
        tick(1);
        run = 1'b0;
        busy = 0;
        while (counting_o && busy < 100) begin
            busy = busy + 1;
            tick(1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hi"}, hi_o, 32'h0);
        check({tag, "_lo"}, lo_o, 32'h0);
        check({tag, "_counting"}, {31'd0, counting_o}, 32'h0);
        check({tag, "_ready"}, {31'd0, ready_o}, 32'h0);
    endtask

    initial begin
        int busy;
        int cnt_hi;

        #1 rst = 1'b0;
        #1 check_zero("reset");
        tick(2);
        rst = 1'b1;
        tick(1);

        // 3 x 5, including the state right after the start edge
        mcand_in = 32'h3; mplier_in = 32'h5; run = 1'b1;
        tick(1);
        run = 1'b0;
        check("e0_counting", {31'd0, counting_o}, 32'h1);
        check("e0_ready", {31'd0, ready_o}, 32'h0);
        check("e0_lo", lo_o, 32'h5);
        check("e0_hi", hi_o, 32'h0);
        busy = 0;
        while (counting_o && busy < 100) begin busy = busy + 1; tick(1); end
        check("3x5_busy", busy, 32'd32);
        check("3x5_ready", {31'd0, ready_o}, 32'h1);
        check("3x5_hi", hi_o, 32'h0);
        check("3x5_lo", lo_o, 32'hF);

        // carry preservation
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, busy);
        check("ff_busy", busy, 32'd32);
        check("ff_hi", hi_o, 32'hFFFFFFFE);
        check("ff_lo", lo_o, 32'h00000001);

        run_op(32'h80000000, 32'h2, busy);
        check("msb_hi", hi_o, 32'h1);
        check("msb_lo", lo_o, 32'h0);

        run_op(32'h12345678, 32'h0, busy);
        check("zero_busy", busy, 32'd32);
        check("zero_ready", {31'd0, ready_o}, 32'h1);
        check("zero_hi", hi_o, 32'h0);
        check("zero_lo", lo_o, 32'h0);
        tick(2);

        // run held high for 80 cycles: a single operation
        mcand_in = 32'd7; mplier_in = 32'd9; run = 1'b1;
        cnt_hi = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (counting_o) cnt_hi = cnt_hi + 1;
            if (i == 10) begin mcand_in = 32'hDEADBEEF; mplier_in = 32'h0BADF00D; end
            if (i == 50) begin mcand_in = 32'h11111111; mplier_in = 32'h22222222; end
        end
        check("hold_busy", cnt_hi, 32'd32);
        check("hold_ready", {31'd0, ready_o}, 32'h1);
        check("hold_hi", hi_o, 32'h0);
        check("hold_lo", lo_o, 32'h3F);
        run = 1'b0;
        tick(2);

        // asynchronous reset in the middle of an operation
        mcand_in = 32'hFFFF; mplier_in = 32'hFFFF; run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(10);
        #1 rst = 1'b0;
        #1 check_zero("midrst");
        tick(1);
        rst = 1'b1;
        tick(1);
        run_op(32'd2, 32'd3, busy);
        check("rst_busy", busy, 32'd32);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h6);

        // run pulses during BUSY (iteration 5 and the final edge) are ignored
        mcand_in = 32'd5; mplier_in = 32'd6; run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(4);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(26);
        check("pulse_still_busy", {31'd0, counting_o}, 32'h1);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        check("pulse_ready", {31'd0, ready_o}, 32'h1);
        check("pulse_lo", lo_o, 32'h1E);
        tick(3);
        check("pulse_no_restart", {31'd0, counting_o}, 32'h0);
        check("pulse_hold_lo", lo_o, 32'h1E);

        // fresh start from DONE
        mcand_in = 32'd4; mplier_in = 32'd4; run = 1'b1;
        tick(1);
        run = 1'b0;
        check("redo_ready", {31'd0, ready_o}, 32'h0);
        check("redo_counting", {31'd0, counting_o}, 32'h1);
        check("redo_lo0", lo_o, 32'h4);
        busy = 0;
        while (counting_o && busy < 100) begin busy = busy + 1; tick(1); end
        check("redo_busy", busy, 32'd32);
        check("redo_lo", lo_o, 32'h10);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
